tick_timer_arbiter: RTL
=======================

# tick_timer_arbiter

Shares the single 100 ms tick generator between two requesters (A, B) as one countdown timer. Grants ownership round-robin, drives the generator's `enable`, counts the returned `ms100` pulses down from the owner's requested duration, and returns a one-cycle `done` pulse to the owner. Sits between game-control FSMs and the 100 ms timebase.

## Interface
- `DUR_W`, 8, width of duration and remaining count, in 100 ms units
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high; takes effect on the next rising `clk` edge.
- `req_a` in 1: A requests the timer; level, held until `done_a`.
- `dur_a` in DUR_W: A's duration; sampled only at grant.
- `req_b` in 1: B requests the timer; same rules as `req_a`.
- `dur_b` in DUR_W: B's duration; same rules as `dur_a`.
- `abort` in 1: cancels the current run.
- `ms100` in 1: one-cycle tick from the 100 ms generator.
- `tick_en` out 1: drives the generator `enable`.
- `gnt_a` out 1: A owns the timer (level).
- `gnt_b` out 1: B owns the timer (level).
- `done_a` out 1: one-cycle pulse to A at expiry.
- `done_b` out 1: one-cycle pulse to B at expiry.
- `remaining` out DUR_W: ticks left in the current run.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any `req_*` is high, pick the owner and go to RUN.
  - Both high: grant the side not served last. After reset, A has priority.
  - Latch `dur_owner` into `remaining`.
- Zero duration: if the latched duration is 0, go IDLE→DONE directly. `tick_en` never rises.
- RUN:
  - `tick_en`=1, `gnt_owner`=1.
  - On `ms100`, decrement `remaining`.
  - When `remaining`==1 and `ms100` is high, load 0 and go to DONE.
- DONE:
  - Lasts one cycle: `done_owner`=1, `gnt_owner` still 1, `tick_en`=0, `remaining`=0.
  - Update the last-served pointer to the owner, then go to IDLE.
- Cancel: `abort`=1, or the owner dropping `req`, in RUN → go to IDLE next cycle.
  - No `done` pulse.
  - Last-served pointer still updates to the owner.
  - `remaining` is cleared.
- Priority within one cycle: rst > abort/req-drop > `ms100`.
- `ms100` is ignored outside RUN.
- `dur_*` changes after grant have no effect.
- The requester must deassert `req` in the cycle after seeing `done`. A `req` still high in IDLE is a new request.

## Timing
- Reset values: `tick_en`=0, `gnt_*`=0, `done_*`=0, `remaining`=0, `busy`=0, state IDLE, last-served=B (so A wins the first tie).
- All outputs are registered.
- Grant latency: `req` high at edge n → `gnt`, `busy`, `tick_en` and `remaining`=dur valid after edge n.
- `tick_en` drops for at least one cycle between runs. This resets the generator's phase, so the first tick of every run comes one full 100 ms period after the grant.
- Expiry latency: the final `ms100` seen at edge m → `done` high for the cycle after edge m.
- Run length: duration D gives D `ms100` periods (plus grant and done cycles), about D×100 ms.
- Zero-duration latency: `gnt` and `done` appear in consecutive cycles.
- Back-to-back ownership: DONE → IDLE → new grant. Minimum gap is one IDLE cycle with `gnt_*`=0.
- Reset mid-run: all outputs return to their reset values after the next edge. No `done` is issued.

## Structure
- Package `tick_timer_pkg`:
  - state enum {IDLE, RUN, DONE}
  - owner encoding (A=0, B=1)
  - default `DUR_W`
- Sub-module `rr_arbiter2`:
  - 2-way round-robin arbiter.
  - Inputs: `req_a`, `req_b`, last-served pointer.
  - Output: one-hot grant select.
  - Combinational. The pointer register lives in the parent.
- The top level holds the FSM, the countdown register and the output registers.
- Top level and arbiter together: about 150–250 lines.

## Test plan
- Reset, then `req_a`=1, `dur_a`=3, ms100 every 10 cycles → `gnt_a`/`tick_en` one edge later, `remaining` 3→2→1→0, `done_a` one cycle after the 3rd tick, then IDLE.
- Both requesting at the same edge after reset (`dur_a`=2, `dur_b`=1) → A granted first; after `done_a`, B granted; with both still requesting, the next winner is A (alternation).
- `dur_b`=0 → `gnt_b` then `done_b` in the next cycle; `tick_en` stays 0 throughout.
- `abort` asserted in the same cycle as `ms100` while `remaining`=1 → no `done`, IDLE next cycle, `remaining`=0.
- Owner drops `req` mid-run → cancel with no `done`; the other side's pending request is granted after one IDLE cycle.
- `rst` asserted while `remaining`=5 → all outputs 0 after the next edge; a `ms100` pulse during reset is ignored.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// -----------------------------------------------------------------------------
// tick_timer_pkg
//
// Shared types for the tick timer arbiter:
//   - state_t       : controller states (IDLE, RUN, DONE)
//   - owner_t       : which requester currently owns the timer (A=0, B=1)
//   - DUR_W_DEFAULT : default width of durations / remaining count (100 ms units)
//   - owner_onehot  : maps an owner to a {B, A} one-hot pair, used to steer
//                     the per-requester grant and done outputs
// -----------------------------------------------------------------------------
package tick_timer_pkg;

    localparam int DUR_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    // Bit 0 selects A, bit 1 selects B.
    function automatic logic [1:0] owner_onehot(input owner_t owner);
        return (owner == OWNER_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tick_timer_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//
// Two-way round-robin arbiter, purely combinational. The last-served pointer
// is held by the parent so that it can be updated only when a run ends.
//
// Ports:
//   req_a       in  : A is requesting
//   req_b       in  : B is requesting
//   last_served in  : owner served most recently
//   gnt_sel     out : one-hot winner, bit 0 = A, bit 1 = B; 2'b00 when idle
// -----------------------------------------------------------------------------
module rr_arbiter2
    import tick_timer_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  owner_t     last_served,
    output logic [1:0] gnt_sel
);

    always_comb begin
        gnt_sel = 2'b00;
        if (req_a && req_b) begin
            // Tie: hand the timer to whoever was not served last.
            gnt_sel = (last_served == OWNER_B) ? 2'b01 : 2'b10;
        end else if (req_a) begin
            gnt_sel = 2'b01;
        end else if (req_b) begin
            gnt_sel = 2'b10;
        end
    end

endmodule

// File: rtl/tick_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tick_timer_arbiter
//
// Shares one 100 ms tick generator between two requesters (A, B) as a single
// countdown timer. The winner's duration is latched at grant, the generator is
// enabled while the run is active, each ms100 pulse decrements the count, and
// a one-cycle done pulse goes back to the owner at expiry. Abort or the owner
// dropping its request cancels the run without a done pulse.
//
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset
//   req_a/b    in  : level requests, held until the matching done
//   dur_a/b    in  : requested durations, sampled only at grant
//   abort      in  : cancel the current run
//   ms100      in  : one-cycle tick from the 100 ms generator
//   tick_en    out : generator enable
//   gnt_a/b    out : ownership level
//   done_a/b   out : one-cycle expiry pulse
//   remaining  out : ticks left in the current run
//   busy       out : controller not in IDLE
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module tick_timer_arbiter
    import tick_timer_pkg::*;
#(
    parameter int DUR_W = DUR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [DUR_W-1:0] dur_a,
    input  logic             req_b,
    input  logic [DUR_W-1:0] dur_b,
    input  logic             abort,
    input  logic             ms100,
    output logic             tick_en,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic [DUR_W-1:0] remaining,
    output logic             busy
);

    state_t           state_q;
    owner_t           owner_q;
    owner_t           last_q;
    logic [DUR_W-1:0] remaining_q;
    logic             tick_en_q;
    logic             gnt_a_q;
    logic             gnt_b_q;
    logic             done_a_q;
    logic             done_b_q;
    logic             busy_q;

    logic [1:0]       gnt_sel;
    logic [DUR_W-1:0] dur_sel;
    logic             owner_req;

    rr_arbiter2 u_arb (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_served (last_q),
        .gnt_sel     (gnt_sel)
    );

    // Duration of the side the arbiter is picking this cycle.
    assign dur_sel   = gnt_sel[1] ? dur_b : dur_a;

    // Request level of the current owner; dropping it cancels the run.
    assign owner_req = (owner_q == OWNER_B) ? req_b : req_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_A;
            last_q      <= OWNER_B;   // so A wins the first tie
            remaining_q <= '0;
            tick_en_q   <= 1'b0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the RUN->DONE step raises it.
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (gnt_sel != 2'b00) begin
                        owner_q            <= gnt_sel[1] ? OWNER_B : OWNER_A;
                        {gnt_b_q, gnt_a_q} <= gnt_sel;
                        remaining_q        <= dur_sel;
                        // A zero-length run never enables the generator; it
                        // spends its grant cycle in RUN and expires next edge.
                        tick_en_q          <= (dur_sel != '0);
                        busy_q             <= 1'b1;
                        state_q            <= RUN;
                    end
                end

                RUN: begin
                    if (abort || !owner_req) begin
                        // Cancel wins over a coincident ms100: no done pulse,
                        // but the owner still counts as served.
                        state_q     <= IDLE;
                        last_q      <= owner_q;
                        remaining_q <= '0;
                        tick_en_q   <= 1'b0;
                        gnt_a_q     <= 1'b0;
                        gnt_b_q     <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (remaining_q == '0) begin
                        // Zero-duration grant: expire without any tick.
                        state_q              <= DONE;
                        tick_en_q            <= 1'b0;
                        {done_b_q, done_a_q} <= owner_onehot(owner_q);
                    end else if (ms100) begin
                        if (remaining_q == DUR_W'(1)) begin
                            state_q              <= DONE;
                            remaining_q          <= '0;
                            tick_en_q            <= 1'b0;
                            {done_b_q, done_a_q} <= owner_onehot(owner_q);
                        end else begin
                            remaining_q <= remaining_q - DUR_W'(1);
                        end
                    end
                end

                DONE: begin
                    // Grant is held through the done cycle, then released.
                    // Requests seen here are ignored; they are re-evaluated
                    // in IDLE, which guarantees a one-cycle gap between owners.
                    state_q     <= IDLE;
                    last_q      <= owner_q;
                    remaining_q <= '0;
                    tick_en_q   <= 1'b0;
                    gnt_a_q     <= 1'b0;
                    gnt_b_q     <= 1'b0;
                    busy_q      <= 1'b0;
                end

                default: begin
                    state_q     <= IDLE;
                    remaining_q <= '0;
                    tick_en_q   <= 1'b0;
                    gnt_a_q     <= 1'b0;
                    gnt_b_q     <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign tick_en   = tick_en_q;
    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign done_a    = done_a_q;
    assign done_b    = done_b_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;

endmodule
